// File: rtl/miner_csr_pkg.sv
// Shared constants and types for the multi-core miner CSR block.
package miner_csr_pkg;

    // Widest nonce any build supports; narrower nonces are zero-extended.
    localparam int unsigned NONCE_MAX_W = 128;

    // Word addresses
    localparam logic [4:0] ADDR_STAT   = 5'd0;
    localparam logic [4:0] ADDR_ID     = 5'd1;
    localparam logic [4:0] ADDR_FSTAT  = 5'd2;
    localparam logic [4:0] ADDR_POP    = 5'd3;
    localparam logic [4:0] ADDR_HEAD   = 5'd4;
    localparam logic [4:0] ADDR_HEADER = 5'd8;
    localparam logic [4:0] ADDR_DIFF   = 5'd16;
    localparam logic [4:0] ADDR_START  = 5'd24;
    localparam logic [4:0] ADDR_CTL    = 5'd28;
    localparam logic [4:0] ADDR_ISTAT  = 5'd29;
    localparam logic [4:0] ADDR_PERF   = 5'd30;

    // CTL bit positions
    localparam int unsigned CTL_RUN    = 0;
    localparam int unsigned CTL_TEST   = 1;
    localparam int unsigned CTL_HALT   = 2;
    localparam int unsigned CTL_IRQ_EN = 3;
    localparam logic [31:0] CTL_MASK   = 32'hFFFF_000F;

    // STAT bit positions
    localparam int unsigned STAT_NONEMPTY = 0;
    localparam int unsigned STAT_BUSY     = 1;
    localparam int unsigned STAT_TEST     = 2;

    // FSTAT bit positions
    localparam int unsigned FSTAT_HEAD_LSB = 8;
    localparam int unsigned FSTAT_OVF      = 16;

    // ISTAT bit positions
    localparam int unsigned ISTAT_SOLN = 0;
    localparam int unsigned ISTAT_OVF  = 1;

    localparam logic [31:0] ID_SHA3 = 32'h5348_4133;

    typedef struct packed {
        logic [2:0]             core_id;
        logic [NONCE_MAX_W-1:0] nonce;
    } soln_t;

    // 32-bit word idx of a zero-extended nonce, LSW first.
    function automatic logic [31:0] nonce_word(logic [NONCE_MAX_W-1:0] v, logic [1:0] idx);
        return v[{idx, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/miner_csr_multi_if.sv
// Avalon-MM slave bus bundle for the miner CSR block.
interface miner_csr_multi_if;
    logic [4:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (output address, read, write, writedata, input readdata, irq);
    modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

// File: rtl/miner_soln_fifo.sv
// Synchronous FIFO for solution entries; head is the registered oldest entry.
module miner_soln_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // Storage write; no reset needed since empty gates all use of the contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/miner_csr_multi.sv
// Avalon-MM CSR block for NUM_CORES parallel SHA3 miner cores.
// Optional build macro MINER_PERF_CNT_EN adds a saturating busy-cycle counter at word 30.
module miner_csr_multi
    import miner_csr_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned NONCE_W    = 64,
    parameter int unsigned SOLN_DEPTH = 4,
    parameter int unsigned CLK_MHZ    = 60,
    parameter int unsigned MAJ_VER    = 1,
    parameter int unsigned MIN_VER    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    miner_csr_multi_if.slave               bus,
    output logic [255:0]                   core_header,
    output logic [255:0]                   core_difficulty,
    output logic [NUM_CORES*NONCE_W-1:0]   core_start_nonce,
    output logic [7:0]                     core_stride,
    output logic [18:0]                    core_ctl,
    input  logic [NUM_CORES-1:0]           core_found,
    input  logic [NUM_CORES*NONCE_W-1:0]   core_soln,
    input  logic [NUM_CORES-1:0]           core_busy
);

    localparam int unsigned NW    = NONCE_W / 32;
    localparam int unsigned CNT_W = $clog2(SOLN_DEPTH + 1);

    logic [31:0]          header_q [8];
    logic [31:0]          diff_q [8];
    logic [NONCE_W-1:0]   start_q;
    logic [31:0]          ctl_q;
    logic                 ovf_q;
    logic                 irq_q;
    logic [31:0]          readdata_q;
    logic [31:0]          rd_data;
    logic [31:0]          perf_val;

    logic [NUM_CORES-1:0] pending_q, pending_d;
    logic [NONCE_W-1:0]   cap_q [NUM_CORES];
    logic [2:0]           rr_q, rr_d;
    logic                 grant_vld, grant_ok, ovf_evt;
    logic [2:0]           grant_idx;
    logic [NONCE_W-1:0]   grant_nonce;

    soln_t                push_entry, head_entry;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0]     fifo_count;

    logic                 wr_ctl, run_start;
    logic [31:0]          stat, fstat, istat;

    assign wr_ctl    = bus.write && (bus.address == ADDR_CTL);
    assign run_start = wr_ctl && bus.writedata[CTL_RUN] && !ctl_q[CTL_RUN];
    assign fifo_pop  = bus.write && (bus.address == ADDR_POP);

    // Broadcast outputs; header word at address 8 lands in the MSBs.
    for (genvar g = 0; g < 8; g++) begin : g_bcast
        assign core_header[255-32*g -: 32]     = header_q[g];
        assign core_difficulty[255-32*g -: 32] = diff_q[g];
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_nonce
        assign core_start_nonce[i*NONCE_W +: NONCE_W] = start_q + NONCE_W'(i);
    end

    assign core_stride = 8'(NUM_CORES);
    assign core_ctl    = {ctl_q[31:24], ctl_q[23:16], ctl_q[CTL_HALT], ctl_q[CTL_TEST],
                          ctl_q[CTL_RUN]};

    // Round-robin: lowest pending index at or above rr_q, else lowest pending overall.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                grant_vld = 1'b1;
                grant_idx = 3'(k);
            end
        end
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (pending_q[k] && (3'(k) >= rr_q)) begin
                grant_idx = 3'(k);
            end
        end
        grant_ok = grant_vld & ~fifo_full;
        rr_d = rr_q;
        if (grant_ok) begin
            rr_d = (grant_idx == 3'(NUM_CORES - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    // Pending flags; a found on the granted core re-arms it without counting as overflow.
    always_comb begin
        pending_d   = pending_q;
        ovf_evt     = 1'b0;
        grant_nonce = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (grant_idx == 3'(k)) grant_nonce = cap_q[k];
            pending_d[k] = core_found[k] |
                           (pending_q[k] & ~(grant_ok && (grant_idx == 3'(k))));
            if (core_found[k] && pending_q[k] && !(grant_ok && (grant_idx == 3'(k)))) begin
                ovf_evt = 1'b1;
            end
        end
        push_entry.core_id = grant_idx;
        push_entry.nonce   = NONCE_MAX_W'(grant_nonce);
    end

    // Capture stage state and arbiter pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            rr_q      <= '0;
            for (int k = 0; k < NUM_CORES; k++) cap_q[k] <= '0;
        end else begin
            pending_q <= pending_d;
            rr_q      <= rr_d;
            for (int k = 0; k < NUM_CORES; k++) begin
                if (core_found[k]) cap_q[k] <= core_soln[k*NONCE_W +: NONCE_W];
            end
        end
    end

    miner_soln_fifo #(
        .WIDTH ($bits(soln_t)),
        .DEPTH (SOLN_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_ok),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head_entry)
    );

    // Host-writable configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
            ctl_q   <= '0;
            for (int k = 0; k < 8; k++) begin
                header_q[k] <= '0;
                diff_q[k]   <= '0;
            end
        end else if (bus.write) begin
            if (bus.address[4:3] == 2'b01) header_q[bus.address[2:0]] <= bus.writedata;
            if (bus.address[4:3] == 2'b10) diff_q[bus.address[2:0]]   <= bus.writedata;
            if (bus.address[4:2] == ADDR_START[4:2]) begin
                for (int k = 0; k < NW; k++) begin
                    if (bus.address[1:0] == 2'(k)) start_q[k*32 +: 32] <= bus.writedata;
                end
            end
            if (wr_ctl) ctl_q <= bus.writedata & CTL_MASK;
        end
    end

    // Sticky overflow; a new overflow in the clearing cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (ovf_evt) begin
            ovf_q <= 1'b1;
        end else if (bus.write && (bus.address == ADDR_ISTAT) && bus.writedata[ISTAT_OVF]) begin
            ovf_q <= 1'b0;
        end
    end

`ifdef MINER_PERF_CNT_EN
    logic [31:0] perf_q;

    // Saturating busy-cycle counter, restarted by each run 0->1 write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (run_start) begin
            perf_q <= '0;
        end else if ((|core_busy) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_val = perf_q;
`else
    assign perf_val = 32'd0;
`endif

    assign stat  = {8'(NUM_CORES), 4'(MIN_VER), 4'(MAJ_VER), 8'(CLK_MHZ), 5'b0,
                    ctl_q[CTL_TEST], |core_busy, ~fifo_empty};
    assign fstat = {15'b0, ovf_q, 5'b0, (fifo_empty ? 3'd0 : head_entry.core_id), 3'b0,
                    5'(fifo_count)};
    assign istat = {30'b0, ovf_q, ~fifo_empty};

    // Read mux built from current register values, so read-during-write returns old data.
    always_comb begin
        rd_data = '0;
        case (bus.address[4:3])
            2'b00: begin
                if (bus.address[2]) begin
                    if (!fifo_empty) rd_data = nonce_word(head_entry.nonce, bus.address[1:0]);
                end else begin
                    case (bus.address[1:0])
                        2'd0:    rd_data = stat;
                        2'd1:    rd_data = ID_SHA3;
                        2'd2:    rd_data = fstat;
                        default: rd_data = '0;
                    endcase
                end
            end
            2'b01: rd_data = header_q[bus.address[2:0]];
            2'b10: rd_data = diff_q[bus.address[2:0]];
            default: begin
                if (!bus.address[2]) begin
                    rd_data = nonce_word(NONCE_MAX_W'(start_q), bus.address[1:0]);
                end else begin
                    case (bus.address[1:0])
                        2'd0:    rd_data = ctl_q;
                        2'd1:    rd_data = istat;
                        2'd2:    rd_data = perf_val;
                        default: rd_data = '0;
                    endcase
                end
            end
        endcase
    end

    // Registered read data (held between reads) and level interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (bus.read) readdata_q <= rd_data;
            irq_q <= ctl_q[CTL_IRQ_EN] & (~fifo_empty | ovf_q);
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_miner_csr_multi.sv
// Directed, table-driven bench for miner_csr_multi (NUM_CORES=4, NONCE_W=64, depth 4).
module tb_miner_csr_multi;

    localparam int unsigned NC = 4;
    localparam int unsigned NWID = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [255:0]       core_header, core_difficulty;
    logic [NC*NWID-1:0] core_start_nonce;
    logic [7:0]         core_stride;
    logic [18:0]        core_ctl;
    logic [NC-1:0]      core_found = '0;
    logic [NC*NWID-1:0] core_soln = '0;
    logic [NC-1:0]      core_busy = '0;

    int checks = 0;
    int failures = 0;

    miner_csr_multi_if bus ();

    miner_csr_multi dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .core_header      (core_header),
        .core_difficulty  (core_difficulty),
        .core_start_nonce (core_start_nonce),
        .core_stride      (core_stride),
        .core_ctl         (core_ctl),
        .core_found       (core_found),
        .core_soln        (core_soln),
        .core_busy        (core_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        bus.write = 1'b1;
        bus.writedata = d;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic check_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, {32'b0, d}, {32'b0, exp});
    endtask

    task automatic found(input logic [3:0] mask, input logic [63:0] n0, input logic [63:0] n1,
                         input logic [63:0] n2, input logic [63:0] n3);
        @(negedge clk);
        core_found = mask;
        core_soln = {n3, n2, n1, n0};
        @(negedge clk);
        core_found = '0;
    endtask

    logic [31:0] d;
    logic [2:0]  exp_id [4];
    logic [31:0] exp_nonce [4];
    logic [31:0] exp_perf;

    initial begin
        bus.address = '0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.writedata = '0;

        // Reset state
        tick(3);
        check("rst_readdata", {32'b0, bus.readdata}, 64'h0);
        check("rst_irq", {63'b0, bus.irq}, 64'h0);
        check("rst_core_ctl", {45'b0, core_ctl}, 64'h0);
        check("stride", {56'b0, core_stride}, 64'd4);
        rst = 1'b0;

        // Register map vectors
        vecs.push_back('{"stat_rst",   1'b0, 5'd0,  32'h0,         32'h0401_3C00});
        vecs.push_back('{"id",         1'b0, 5'd1,  32'h0,         32'h5348_4133});
        vecs.push_back('{"fstat_rst",  1'b0, 5'd2,  32'h0,         32'h0});
        vecs.push_back('{"perf_rst",   1'b0, 5'd30, 32'h0,         32'h0});
        vecs.push_back('{"head_empty", 1'b0, 5'd5,  32'h0,         32'h0});
        vecs.push_back('{"",           1'b1, 5'd8,  32'hA0A0_0001, 32'h0});
        vecs.push_back('{"header8",    1'b0, 5'd8,  32'h0,         32'hA0A0_0001});
        vecs.push_back('{"",           1'b1, 5'd15, 32'h1234_5678, 32'h0});
        vecs.push_back('{"header15",   1'b0, 5'd15, 32'h0,         32'h1234_5678});
        vecs.push_back('{"",           1'b1, 5'd16, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{"diff16",     1'b0, 5'd16, 32'h0,         32'hDEAD_BEEF});
        vecs.push_back('{"",           1'b1, 5'd26, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{"start_w2",   1'b0, 5'd26, 32'h0,         32'h0});
        vecs.push_back('{"",           1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{"unmapped31", 1'b0, 5'd31, 32'h0,         32'h0});
        vecs.push_back('{"",           1'b1, 5'd28, 32'hAB12_3456, 32'h0});
        vecs.push_back('{"ctl_mask",   1'b0, 5'd28, 32'h0,         32'hAB12_0006});
        vecs.push_back('{"stat_test",  1'b0, 5'd0,  32'h0,         32'h0401_3C04});
        foreach (vecs[i]) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else check_rd(vecs[i].name, vecs[i].addr, vecs[i].exp);
        end
        check("core_ctl_fields", {45'b0, core_ctl}, 64'h5_5896);
        check("core_header_msw", {32'b0, core_header[255:224]}, 64'hA0A0_0001);
        check("core_header_lsw", {32'b0, core_header[31:0]}, 64'h1234_5678);
        check("core_diff_msw", {32'b0, core_difficulty[255:224]}, 64'hDEAD_BEEF);
        bus_write(5'd28, 32'h0);

        // Read latency: readdata holds until the edge after read
        @(negedge clk);
        bus.address = 5'd1;
        bus.read = 1'b1;
        #1 check("latency_hold", {32'b0, bus.readdata}, 64'h0401_3C04);
        @(negedge clk);
        bus.read = 1'b0;
        check("latency_new", {32'b0, bus.readdata}, 64'h5348_4133);

        // Start nonce wrap and run rise
        bus_write(5'd24, 32'hFFFF_FFFE);
        bus_write(5'd25, 32'hFFFF_FFFF);
        @(negedge clk);
        bus.address = 5'd28;
        bus.write = 1'b1;
        bus.writedata = 32'h9;
        #1 check("run_before", {63'b0, core_ctl[0]}, 64'h0);
        @(negedge clk);
        bus.write = 1'b0;
        check("run_after", {63'b0, core_ctl[0]}, 64'h1);
        check("nonce0", core_start_nonce[63:0], 64'hFFFF_FFFF_FFFF_FFFE);
        check("nonce1", core_start_nonce[127:64], 64'hFFFF_FFFF_FFFF_FFFF);
        check("nonce2", core_start_nonce[191:128], 64'h0);
        check("nonce3", core_start_nonce[255:192], 64'h1);

        // Simultaneous founds on cores 1 and 3
        found(4'b1010, 64'h0, 64'h11, 64'h0, 64'h33);
        tick(3);
        check("irq_soln", {63'b0, bus.irq}, 64'h1);
        check_rd("fstat_two", 5'd2, 32'h0000_0102);
        check_rd("head_c1", 5'd4, 32'h11);
        check_rd("head_c1_w1", 5'd5, 32'h0);
        bus_write(5'd3, 32'h0);
        check_rd("fstat_one", 5'd2, 32'h0000_0301);
        check_rd("head_c3", 5'd4, 32'h33);
        bus_write(5'd3, 32'h0);
        check_rd("fstat_drained", 5'd2, 32'h0);
        tick(2);
        check("irq_clear", {63'b0, bus.irq}, 64'h0);

        // Full FIFO holds pending entries; repeat found on held core overflows
        found(4'hF, 64'h100, 64'h101, 64'h102, 64'h103);
        tick(6);
        check_rd("fstat_full", 5'd2, 32'h0000_0004);
        found(4'h3, 64'h200, 64'h201, 64'h0, 64'h0);
        tick(2);
        found(4'h1, 64'h300, 64'h0, 64'h0, 64'h0);
        tick(2);
        check_rd("fstat_ovf", 5'd2, 32'h0001_0004);
        check_rd("istat_ovf", 5'd29, 32'h3);
        check("irq_ovf", {63'b0, bus.irq}, 64'h1);
        bus_write(5'd3, 32'h0);
        tick(3);
        bus_write(5'd3, 32'h0);
        tick(3);
        check_rd("fstat_refill", 5'd2, 32'h0001_0204);
        bus_write(5'd29, 32'h2);
        check_rd("istat_w1c", 5'd29, 32'h1);
        exp_id = '{3'd2, 3'd3, 3'd0, 3'd1};
        exp_nonce = '{32'h102, 32'h103, 32'h300, 32'h201};
        for (int i = 0; i < 4; i++) begin
            bus_read(5'd2, d);
            check("drain_id", {61'b0, d[10:8]}, {61'b0, exp_id[i]});
            check_rd("drain_nonce", 5'd4, exp_nonce[i]);
            bus_write(5'd3, 32'h0);
        end
        check_rd("fstat_empty", 5'd2, 32'h0);
        tick(2);
        check("irq_idle", {63'b0, bus.irq}, 64'h0);

        // Pop on empty, then push and pop in the same cycle
        bus_write(5'd3, 32'h0);
        check_rd("pop_empty", 5'd2, 32'h0);
        found(4'h4, 64'h0, 64'h0, 64'h55, 64'h0);
        tick(3);
        check_rd("fstat_c2", 5'd2, 32'h0000_0201);
        @(negedge clk);
        core_found = 4'h1;
        core_soln = {64'h0, 64'h0, 64'h0, 64'h66};
        @(negedge clk);
        core_found = '0;
        bus.address = 5'd3;
        bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
        check_rd("pushpop_cnt", 5'd2, 32'h0000_0001);
        check_rd("pushpop_head", 5'd4, 32'h66);
        bus_write(5'd3, 32'h0);

        // Busy-cycle counter: exactly 10 busy cycles
`ifdef MINER_PERF_CNT_EN
        exp_perf = 32'd10;
`else
        exp_perf = 32'd0;
`endif
        check_rd("perf_zero", 5'd30, 32'h0);
        @(negedge clk);
        core_busy = 4'b0010;
        bus_read(5'd0, d);
        check("stat_busy", {32'b0, d}, 64'h0401_3C02);
        tick(8);
        core_busy = '0;
        check_rd("perf_count", 5'd30, exp_perf);
        bus_write(5'd28, 32'h8);
        bus_write(5'd28, 32'h9);
        check_rd("perf_runclr", 5'd30, 32'h0);

        // Asynchronous reset mid-operation
        found(4'h1, 64'h77, 64'h0, 64'h0, 64'h0);
        tick(3);
        check("irq_pre_rst", {63'b0, bus.irq}, 64'h1);
        check_rd("stat_pre_rst", 5'd0, 32'h0401_3C01);
        @(negedge clk);
        core_found = 4'h2;
        #2 rst = 1'b1;
        #1;
        check("arst_irq", {63'b0, bus.irq}, 64'h0);
        check("arst_readdata", {32'b0, bus.readdata}, 64'h0);
        check("arst_core_ctl", {45'b0, core_ctl}, 64'h0);
        check("arst_nonce0", core_start_nonce[63:0], 64'h0);
        check("arst_header", {32'b0, core_header[255:224]}, 64'h0);
        @(negedge clk);
        core_found = '0;
        tick(2);
        rst = 1'b0;
        check_rd("post_fstat", 5'd2, 32'h0);
        check_rd("post_ctl", 5'd28, 32'h0);
        check_rd("post_istat", 5'd29, 32'h0);
        check_rd("post_perf", 5'd30, 32'h0);
        tick(2);
        check("post_irq", {63'b0, bus.irq}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
